// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with one-entry skid buffer, flush and exception merge.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_buf #(
   parameter int LANES  = 7,
   parameter int DATA_W = 32,
   parameter int EXC_W  = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0]       in_pc,
   input  logic [EXC_W-1:0]        in_exccode,
   input  logic                    in_bd,
   input  logic [EXC_W-1:0]        stage_exccode,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [DATA_W-1:0]       out_pc,
   output logic [EXC_W-1:0]        out_exccode,
   output logic                    out_bd
`ifdef PIPE_STAGE_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt
`endif
);
   localparam int PW = LANES*DATA_W + DATA_W + EXC_W + 1;
   logic [PW-1:0]    in_pl, m_pl, s_pl;
   logic             m_valid, s_valid, in_fire, out_fire;
   logic [EXC_W-1:0] exc;
   // earliest-detected exception wins
   assign exc      = (in_exccode != '0) ? in_exccode : stage_exccode;
   assign in_pl    = {in_data, in_pc, exc, in_bd};
   assign in_ready = !s_valid;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = m_valid && out_ready;
   assign out_valid = m_valid;
   // main payload is zeroed whenever it is empty, so idle outputs are a bubble
   assign {out_data, out_pc, out_exccode, out_bd} = m_pl;
   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_pl    <= '0;
         s_pl    <= '0;
      end else if (out_fire || !m_valid) begin
         if (s_valid) begin
            m_valid <= 1'b1;
            m_pl    <= s_pl;
            s_valid <= 1'b0;
            s_pl    <= '0;
         end else begin
            m_valid <= in_fire;
            m_pl    <= in_fire ? in_pl : '0;
         end
      end else if (in_fire) begin
         s_valid <= 1'b1;
         s_pl    <= in_pl;
      end
   end
`ifdef PIPE_STAGE_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (m_valid && !out_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf at LANES=7 (default), 1 and 9.
module tb_pipe_stage_buf;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0, in_bd = 1'b0, flush = 1'b0, out_ready = 1'b1;
   logic [31:0] in_pc = '0;
   logic [4:0] in_exccode = '0, stage_exccode = '0;
   logic [7*32-1:0] d7 = '0, o7_data;
   logic [31:0] d1 = '0, o1_data;
   logic [9*32-1:0] d9 = '0, o9_data;
   logic [31:0] o7_pc, o1_pc, o9_pc;
   logic [4:0] o7_exc, o1_exc, o9_exc;
   logic o7_bd, o1_bd, o9_bd, o7_v, o1_v, o9_v, r7, r1, r9;
`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [31:0] sc7, sc1, sc9;
`endif
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   pipe_stage_buf dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r7), .in_data(d7),
      .in_pc(in_pc), .in_exccode(in_exccode), .in_bd(in_bd), .stage_exccode(stage_exccode),
      .flush(flush), .out_valid(o7_v), .out_ready(out_ready), .out_data(o7_data), .out_pc(o7_pc),
      .out_exccode(o7_exc), .out_bd(o7_bd)
`ifdef PIPE_STAGE_STALL_CNT_EN
      , .stall_cnt(sc7)
`endif
   );
   pipe_stage_buf #(.LANES(1)) dut1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1),
      .in_data(d1), .in_pc(in_pc), .in_exccode(in_exccode), .in_bd(in_bd),
      .stage_exccode(stage_exccode), .flush(flush), .out_valid(o1_v), .out_ready(out_ready),
      .out_data(o1_data), .out_pc(o1_pc), .out_exccode(o1_exc), .out_bd(o1_bd)
`ifdef PIPE_STAGE_STALL_CNT_EN
      , .stall_cnt(sc1)
`endif
   );
   pipe_stage_buf #(.LANES(9)) dut9 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r9),
      .in_data(d9), .in_pc(in_pc), .in_exccode(in_exccode), .in_bd(in_bd),
      .stage_exccode(stage_exccode), .flush(flush), .out_valid(o9_v), .out_ready(out_ready),
      .out_data(o9_data), .out_pc(o9_pc), .out_exccode(o9_exc), .out_bd(o9_bd)
`ifdef PIPE_STAGE_STALL_CNT_EN
      , .stall_cnt(sc9)
`endif
   );

   function automatic logic [31:0] w(input int b, input int k);
      return 32'hA000_0000 + 32'(b << 8) + 32'(k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int b);
      in_pc = 32'h3000 + 32'(4 * b);
      for (int k = 0; k < 7; k++) d7[k*32 +: 32] = w(b, k);
      d1 = w(b, 0);
      for (int k = 0; k < 9; k++) d9[k*32 +: 32] = w(b, k);
   endtask

   task automatic chk_lanes(input string tag, input int b);
      chk({tag, "_l7_0"}, 64'(o7_data[31:0]), 64'(w(b, 0)));
      chk({tag, "_l7_6"}, 64'(o7_data[6*32 +: 32]), 64'(w(b, 6)));
      chk({tag, "_l1_0"}, 64'(o1_data), 64'(w(b, 0)));
      chk({tag, "_l9_0"}, 64'(o9_data[31:0]), 64'(w(b, 0)));
      chk({tag, "_l9_8"}, 64'(o9_data[8*32 +: 32]), 64'(w(b, 8)));
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_v"}, 64'(o7_v), 64'd0);
      chk({tag, "_pc"}, 64'(o7_pc), 64'd0);
      chk({tag, "_data"}, 64'(o7_data == '0), 64'd1);
      chk({tag, "_d9"}, 64'(o9_data == '0), 64'd1);
      chk({tag, "_rdy"}, 64'(r7), 64'd1);
   endtask

   initial begin
      #1 reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk_empty("reset");
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("reset_cnt", 64'(sc7), 64'd0);
`endif
      // streaming: one beat per cycle, 1-cycle latency
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(i);
         step();
         chk($sformatf("stream_pc%0d", i), 64'(o7_pc), 64'h3000 + 64'(4 * i));
         chk($sformatf("stream_v%0d", i), 64'(o7_v), 64'd1);
         chk($sformatf("stream_rdy%0d", i), 64'(r7), 64'd1);
      end
      chk_lanes("stream9", 9);
      in_valid = 1'b0;
      step();
      chk_empty("drain");
      // exception merge and delay-slot flag
      in_valid = 1'b1;
      drive(20);
      stage_exccode = 5'd4;
      step();
      chk("exc_stage", 64'(o7_exc), 64'd4);
      drive(21);
      in_exccode = 5'd10;
      in_bd = 1'b1;
      step();
      chk("exc_in", 64'(o7_exc), 64'd10);
      chk("bd", 64'(o7_bd), 64'd1);
      chk("exc_d9", 64'(o9_exc), 64'd10);
      in_valid = 1'b0;
      in_exccode = '0;
      stage_exccode = '0;
      in_bd = 1'b0;
      step();
      chk("exc_clear", 64'(o7_exc), 64'd0);
      chk("bd_clear", 64'(o7_bd), 64'd0);
      // backpressure: out_ready low for 3 edges
      in_valid = 1'b1;
      drive(30);
      step();
      chk("bp_m30", 64'(o7_pc), 64'h3000 + 64'd120);
      drive(31);
      out_ready = 1'b0;
      step();
      chk("bp_hold30", 64'(o7_pc), 64'h3000 + 64'd120);
      chk("bp_rdy_lo", 64'(r7), 64'd0);
      drive(32);
      step();
      chk("bp_rdy_lo2", 64'(r7), 64'd0);
      step();
      chk("bp_hold30b", 64'(o7_pc), 64'h3000 + 64'd120);
      chk_lanes("bp30", 30);
      out_ready = 1'b1;
      step();
      chk("bp_s31", 64'(o7_pc), 64'h3000 + 64'd124);
      chk("bp_rdy_hi", 64'(r7), 64'd1);
      chk_lanes("bp31", 31);
      step();
      chk("bp_m32", 64'(o7_pc), 64'h3000 + 64'd128);
      chk_lanes("bp32", 32);
      in_valid = 1'b0;
      step();
      chk("bp_drain", 64'(o7_v), 64'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("bp_cnt", 64'(sc7), 64'd3);
`endif
      // flush with both entries full and a beat offered
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(40);
      step();
      drive(41);
      step();
      chk("fl_full", 64'(r7), 64'd0);
      flush = 1'b1;
      drive(42);
      step();
      chk_empty("flush");
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk_empty("flush_after");
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("fl_cnt", 64'(sc7), 64'd5);
`endif
      // asynchronous reset between edges with both entries full
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(50);
      step();
      drive(51);
      step();
      in_valid = 1'b0;
      chk("ar_full", 64'(r7), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk_empty("async_rst");
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("ar_cnt", 64'(sc7), 64'd0);
`endif
      #1 reset = 1'b0;
      out_ready = 1'b1;
      step();
      chk_empty("ar_after");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
